// File: rtl/parity_sweep_checker.sv
// parity_sweep_checker: drives every input vector 0..2^N_IN-1 into a
// combinational (optionally pipelined) parity candidate and scores its single
// output against true odd parity. The mismatch count is the candidate's
// fitness figure. Legal ranges: N_IN 2..8, DUT_LATENCY 0..3.
module parity_sweep_checker #(
    parameter int N_IN         = 5,
    parameter int DUT_LATENCY  = 0,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] pi_vec,
    input  logic            po0,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam logic [N_IN-1:0] LAST_VEC = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   ERR_ONE  = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN:0]   ERR_MAX  = {1'b1, {N_IN{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // A tag follows each issued vector through the candidate's latency so the
    // compare knows which vector the sampled po0 belongs to.
    typedef struct packed {
        logic            valid;
        logic [N_IN-1:0] vec;
    } tag_t;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_int;

    // Shift ones into the synchronizer once the external reset is released.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchronizer register.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_n_int = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [N_IN-1:0] pi_vec_q, pi_vec_d;
    logic [N_IN:0]   err_count_q, err_count_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
    logic            pass_q, pass_d;

    tag_t issue_tag;   // vector currently on pi_vec, valid while RUN
    tag_t cmp_tag;     // vector whose result is on po0 this cycle
    logic pipe_flush;  // discard all in-flight tags
    logic mismatch;

    assign issue_tag = '{valid: (state_q == S_RUN), vec: pi_vec_q};

    // ------------------------------------------------------------------
    // Tag delay pipe matching the candidate's register stages.
    // ------------------------------------------------------------------
    if (DUT_LATENCY == 0) begin : g_no_pipe
        assign cmp_tag = issue_tag;
    end else begin : g_pipe
        tag_t pipe_q [DUT_LATENCY];
        tag_t pipe_d [DUT_LATENCY];

        // Shift the issued tag down the pipe, or clear it on flush.
        always_comb begin
            pipe_d[0] = pipe_flush ? '0 : issue_tag;
            for (int i = 1; i < DUT_LATENCY; i++) begin
                pipe_d[i] = pipe_flush ? '0 : pipe_q[i-1];
            end
        end

        // Tag pipe register.
        // NOTE: the pipe is reset because a stale valid bit after reset would
        // trigger a bogus compare; it is only a few flops deep.
        always_ff @(posedge clk or negedge rst_n_int) begin
            if (!rst_n_int) begin
                for (int i = 0; i < DUT_LATENCY; i++) pipe_q[i] <= '0;
            end else begin
                for (int i = 0; i < DUT_LATENCY; i++) pipe_q[i] <= pipe_d[i];
            end
        end

        assign cmp_tag = pipe_q[DUT_LATENCY-1];
    end

    // Next-state, vector stepping and result scoring.
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        state_d     = state_q;
        pi_vec_d    = pi_vec_q;
        err_count_d = err_count_q;
        ffv_d       = ffv_q;
        ffvec_d     = ffvec_q;
        pass_d      = pass_q;
        pipe_flush  = 1'b0;
        mismatch    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    pi_vec_d    = '0;
                    err_count_d = '0;
                    ffv_d       = 1'b0;
                    ffvec_d     = '0;
                    pass_d      = 1'b0;
                    pipe_flush  = 1'b1;
                end
            end
            S_RUN: begin
                // The last vector holds on pi_vec; it never wraps.
                if (pi_vec_q != LAST_VEC) pi_vec_d = pi_vec_q + VEC_ONE;
                else                      state_d  = S_DRAIN;
            end
            S_DRAIN: begin
                // Waiting for in-flight tags; scoring happens below.
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // po0 is only looked at on a compare edge, so X elsewhere is harmless.
        if ((state_q == S_RUN || state_q == S_DRAIN) && cmp_tag.valid) begin
            mismatch = (po0 != ^cmp_tag.vec);
            if (mismatch) begin
                if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_ONE;
                if (!ffv_q) begin
                    ffv_d   = 1'b1;
                    ffvec_d = cmp_tag.vec;
                end
            end
            if (STOP_ON_FAIL && mismatch) begin
                state_d    = S_DONE;
                pipe_flush = 1'b1;
            end else if (cmp_tag.vec == LAST_VEC) begin
                // Last compare: with zero latency this skips DRAIN entirely.
                state_d = S_DONE;
            end
        end

        if (state_d == S_DONE && state_q != S_DONE) begin
            pass_d = (err_count_d == '0);
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= S_IDLE;
            pi_vec_q    <= '0;
            err_count_q <= '0;
            ffv_q       <= 1'b0;
            ffvec_q     <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pi_vec_q    <= pi_vec_d;
            err_count_q <= err_count_d;
            ffv_q       <= ffv_d;
            ffvec_q     <= ffvec_d;
            pass_q      <= pass_d;
        end
    end

    assign pi_vec           = pi_vec_q;
    assign busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done             = (state_q == S_DONE);
    assign pass             = pass_q;
    assign err_count        = err_count_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_parity_sweep_checker.sv
// Bench for parity_sweep_checker: three instances (latency 0, latency 2,
// latency 0 with stop-on-fail) evaluated against a set of candidate models.
module tb_parity_sweep_checker;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic         start_s [3];
    logic [N-1:0] pi_s    [3];
    logic         po_s    [3];
    logic         busy_s  [3];
    logic         done_s  [3];
    logic         pass_s  [3];
    logic [N:0]   err_s   [3];
    logic         ffv_s   [3];
    logic [N-1:0] ffvec_s [3];
    int           model_s [3];

    // Candidate models: 0 ideal, 1 inverted, 2 stuck-at-0, 3 stuck-at-1,
    // 4 ideal except vector 31.
    function automatic logic model_out(input int m, input logic [N-1:0] v);
        case (m)
            0:       return ^v;
            1:       return ~^v;
            2:       return 1'b0;
            3:       return 1'b1;
            4:       return (v == 5'd31) ? 1'b0 : ^v;
            default: return ^v;
        endcase
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_dut
        if (i == 1) begin : g_lat2
            logic d1_q, d2_q;
            always_ff @(posedge clk) begin
                d1_q <= model_out(model_s[i], pi_s[i]);
                d2_q <= d1_q;
            end
            assign po_s[i] = d2_q;
        end else begin : g_lat0
            assign po_s[i] = model_out(model_s[i], pi_s[i]);
        end

        parity_sweep_checker #(
            .N_IN(N),
            .DUT_LATENCY((i == 1) ? 2 : 0),
            .STOP_ON_FAIL(i == 2)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .start(start_s[i]),
            .pi_vec(pi_s[i]),
            .po0(po_s[i]),
            .busy(busy_s[i]),
            .done(done_s[i]),
            .pass(pass_s[i]),
            .err_count(err_s[i]),
            .first_fail_valid(ffv_s[i]),
            .first_fail_vec(ffvec_s[i])
        );
    end

    typedef struct {
        int dut;
        int model;
        int restart_at;
        int exp_done;
        int exp_err;
        int exp_ffv;
        int exp_ffvec;
    } vec_t;

    vec_t tbl [12];
    vec_t sb_q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int d, input int m, input int r, input int dn,
                                input int e, input int fv, input int fvec);
        vec_t t;
        t.dut = d; t.model = m; t.restart_at = r; t.exp_done = dn;
        t.exp_err = e; t.exp_ffv = fv; t.exp_ffvec = fvec;
        return t;
    endfunction

    // Run one sweep; expected results go into the scoreboard at start and are
    // popped when the done pulse appears.
    task automatic run_sweep(input vec_t t);
        int   idx;
        int   c;
        int   done_at;
        vec_t e;
        idx = t.dut;
        model_s[idx] = t.model;
        @(negedge clk);
        start_s[idx] = 1'b1;
        sb_q.push_back(t);
        @(posedge clk);
        @(negedge clk);
        start_s[idx] = 1'b0;
        c = 0;
        done_at = -1;
        while (done_at < 0 && c < 100) begin
            start_s[idx] = (t.restart_at > 0 && c == t.restart_at - 1);
            if (done_s[idx]) begin
                done_at = c;
            end else begin
                check($sformatf("pi_vec d%0d c%0d", idx, c), int'(pi_s[idx]), (c > 31) ? 31 : c);
                check($sformatf("busy d%0d c%0d", idx, c), int'(busy_s[idx]), 1);
                if (c == 0) begin
                    check("start_clears_err", int'(err_s[idx]), 0);
                    check("start_clears_pass", int'(pass_s[idx]), 0);
                end
                @(negedge clk);
                c++;
            end
        end
        start_s[idx] = 1'b0;
        check($sformatf("done_edge d%0d m%0d", idx, t.model), done_at, t.exp_done);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("err_count", int'(err_s[idx]), e.exp_err);
            check("pass", int'(pass_s[idx]), (e.exp_err == 0) ? 1 : 0);
            check("first_fail_valid", int'(ffv_s[idx]), e.exp_ffv);
            check("first_fail_vec", int'(ffvec_s[idx]), e.exp_ffvec);
            check("busy_at_done", int'(busy_s[idx]), 0);
        end
        @(negedge clk);
        check("done_one_cycle", int'(done_s[idx]), 0);
        check("idle_busy", int'(busy_s[idx]), 0);
        check("err_holds", int'(err_s[idx]), t.exp_err);
        check("pass_holds", int'(pass_s[idx]), (t.exp_err == 0) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            model_s[i] = 0;
        end

        //          dut model restart done err ffv ffvec
        tbl[0]  = mk(0, 0, 0, 32,  0, 0,  0);
        tbl[1]  = mk(0, 1, 0, 32, 32, 1,  0);
        tbl[2]  = mk(1, 2, 0, 34, 16, 1,  1);
        tbl[3]  = mk(2, 2, 0,  2,  1, 1,  1);
        tbl[4]  = mk(0, 0, 5, 32,  0, 0,  0);
        tbl[5]  = mk(1, 0, 0, 34,  0, 0,  0);
        tbl[6]  = mk(1, 1, 0, 34, 32, 1,  0);
        tbl[7]  = mk(2, 0, 0, 32,  0, 0,  0);
        tbl[8]  = mk(2, 1, 0,  1,  1, 1,  0);
        tbl[9]  = mk(0, 3, 0, 32, 16, 1,  0);
        tbl[10] = mk(0, 4, 0, 32,  1, 1, 31);
        tbl[11] = mk(1, 4, 0, 34,  1, 1, 31);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset pi_vec d%0d", i), int'(pi_s[i]), 0);
            check($sformatf("reset busy d%0d", i), int'(busy_s[i]), 0);
            check($sformatf("reset done d%0d", i), int'(done_s[i]), 0);
            check($sformatf("reset pass d%0d", i), int'(pass_s[i]), 0);
            check($sformatf("reset err d%0d", i), int'(err_s[i]), 0);
            check($sformatf("reset ffv d%0d", i), int'(ffv_s[i]), 0);
        end

        for (int i = 0; i < 12; i++) run_sweep(tbl[i]);

        // Reset mid-sweep: outputs clear at once, no done pulse follows.
        model_s[0] = 1;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_err_nonzero", int'(err_s[0] != 0), 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset pi_vec", int'(pi_s[0]), 0);
        check("mid_reset busy", int'(busy_s[0]), 0);
        check("mid_reset err", int'(err_s[0]), 0);
        check("mid_reset ffv", int'(ffv_s[0]), 0);
        check("mid_reset ffvec", int'(ffvec_s[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_done_after_reset", int'(done_s[0]), 0);
            check("idle_after_reset", int'(busy_s[0]), 0);
        end
        run_sweep(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
